// File: rtl/alu_divider_if.sv
// rtl/alu_divider_if.sv - request/result bundle between the CPU core and the 16/8 divider
interface alu_divider_if;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic [7:0]  quotient;
  logic [7:0]  remainder;
  logic        div_zero;
  logic        overflow;
  logic        busy;
  logic        done;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, div_zero, overflow, busy, done
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, div_zero, overflow, busy, done
  );
endinterface

// File: rtl/alu_divider.sv
// rtl/alu_divider.sv - sequential unsigned 16/8 restoring divider, one quotient bit per enabled cycle
module alu_divider (
  input  logic          clk,
  input  logic          reset,
  input  logic          ready,
  alu_divider_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_n;
  logic [7:0]  r, r_n;
  logic [7:0]  q, q_n;
  logic [7:0]  dvs, dvs_n;
  logic [2:0]  cnt, cnt_n;
  logic        dz, dz_n;
  logic        ov, ov_n;

  // Partial remainder shifted left with the next dividend bit; r < divisor keeps it below 2*divisor.
  logic [8:0]  t;
  logic [8:0]  diff;

  // Register update, frozen whenever the core's cycle enable is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      r     <= 8'h00;
      q     <= 8'h00;
      dvs   <= 8'h00;
      cnt   <= 3'd0;
      dz    <= 1'b0;
      ov    <= 1'b0;
    end else if (ready) begin
      state <= state_n;
      r     <= r_n;
      q     <= q_n;
      dvs   <= dvs_n;
      cnt   <= cnt_n;
      dz    <= dz_n;
      ov    <= ov_n;
    end
  end

  // Next-state and datapath: error screening at start, then one restoring step per RUN cycle.
  always_comb begin
    state_n = state;
    r_n     = r;
    q_n     = q;
    dvs_n   = dvs;
    cnt_n   = cnt;
    dz_n    = dz;
    ov_n    = ov;
    t       = {r, q[7]};
    diff    = t - {1'b0, dvs};

    case (state)
      IDLE: begin
        if (bus.start) begin
          dz_n = 1'b0;
          ov_n = 1'b0;
          if (bus.divisor == 8'h00) begin
            dz_n    = 1'b1;
            q_n     = 8'hFF;
            r_n     = bus.dividend[15:8];
            state_n = DONE;
          end else if (bus.dividend[15:8] >= bus.divisor) begin
            ov_n    = 1'b1;
            q_n     = 8'hFF;
            r_n     = bus.dividend[15:8];
            state_n = DONE;
          end else begin
            r_n     = bus.dividend[15:8];
            q_n     = bus.dividend[7:0];
            dvs_n   = bus.divisor;
            cnt_n   = 3'd0;
            state_n = RUN;
          end
        end
      end
      RUN: begin
        if (t >= {1'b0, dvs}) begin
          r_n = diff[7:0];
          q_n = {q[6:0], 1'b1};
        end else begin
          r_n = t[7:0];
          q_n = {q[6:0], 1'b0};
        end
        cnt_n = cnt + 3'd1;
        if (cnt == 3'd7) begin
          state_n = DONE;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign bus.quotient  = q;
  assign bus.remainder = r;
  assign bus.div_zero  = dz;
  assign bus.overflow  = ov;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE);

endmodule

// File: tb/tb_alu_divider.sv
// tb/tb_alu_divider.sv - directed-vector bench for the 16/8 divider
module tb_alu_divider;

  logic clk;
  logic reset;
  logic ready;
  int   n_checks;
  int   n_pass;

  alu_divider_if bus ();

  alu_divider dut (
    .clk   (clk),
    .reset (reset),
    .ready (ready),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one divide from an IDLE cycle; stall_mask bit n drops ready before the (n+1)th edge after start.
  task automatic run_div(input logic [15:0] dvd, input logic [7:0] dvs,
                         input logic [15:0] stall_mask, input logic stall_done,
                         input logic inject, input int exp_lat,
                         input logic [7:0] eq, input logic [7:0] er,
                         input logic edz, input logic eov);
    int n;
    bus.start    = 1'b1;
    bus.dividend = dvd;
    bus.divisor  = dvs;
    ready        = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n = 1;
    while (!bus.done && n < 40) begin
      ready = !stall_mask[n % 16];
      if (inject && n == 4) begin
        bus.start    = 1'b1;
        bus.dividend = 16'h0001;
        bus.divisor  = 8'h01;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    bus.start = 1'b0;
    ready     = 1'b1;
    check("latency",   16'(n),           16'(exp_lat));
    check("quotient",  16'(bus.quotient), 16'(eq));
    check("remainder", 16'(bus.remainder), 16'(er));
    check("div_zero",  16'(bus.div_zero), 16'(edz));
    check("overflow",  16'(bus.overflow), 16'(eov));
    check("busy_done", 16'(bus.busy),     16'h1);
    if (stall_done) begin
      ready = 1'b0;
      @(posedge clk); #1;
      check("done_frozen",  16'(bus.done),     16'h1);
      check("q_frozen",     16'(bus.quotient), 16'(eq));
      ready = 1'b1;
    end
    @(posedge clk); #1;
    check("done_cleared", 16'(bus.done), 16'h0);
    check("busy_cleared", 16'(bus.busy), 16'h0);
  endtask

  initial begin
    n_checks     = 0;
    n_pass       = 0;
    reset        = 1'b1;
    ready        = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = 16'h0000;
    bus.divisor  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_quotient",  16'(bus.quotient),  16'h0);
    check("rst_remainder", 16'(bus.remainder), 16'h0);
    check("rst_div_zero",  16'(bus.div_zero),  16'h0);
    check("rst_overflow",  16'(bus.overflow),  16'h0);
    check("rst_busy",      16'(bus.busy),      16'h0);
    check("rst_done",      16'(bus.done),      16'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Basic divide and edge operands
    run_div(16'h1234, 8'h56, 16'h0, 1'b0, 1'b0, 9, 8'h36, 8'h10, 1'b0, 1'b0);
    run_div(16'h00FF, 8'h01, 16'h0, 1'b0, 1'b0, 9, 8'hFF, 8'h00, 1'b0, 1'b0);
    run_div(16'h0000, 8'hFF, 16'h0, 1'b0, 1'b0, 9, 8'h00, 8'h00, 1'b0, 1'b0);

    // Error cases finish in one cycle
    run_div(16'h1234, 8'h00, 16'h0, 1'b0, 1'b0, 1, 8'hFF, 8'h12, 1'b1, 1'b0);
    run_div(16'h5678, 8'h20, 16'h0, 1'b0, 1'b0, 1, 8'hFF, 8'h56, 1'b0, 1'b1);

    // Stalls during RUN and on the DONE cycle
    run_div(16'h1234, 8'h56, 16'h0054, 1'b1, 1'b0, 12, 8'h36, 8'h10, 1'b0, 1'b0);

    // Start during RUN is ignored, the following IDLE start is accepted
    run_div(16'h1234, 8'h56, 16'h0, 1'b0, 1'b1, 9, 8'h36, 8'h10, 1'b0, 1'b0);
    run_div(16'h0001, 8'h01, 16'h0, 1'b0, 1'b0, 9, 8'h01, 8'h00, 1'b0, 1'b0);

    // Asynchronous reset mid-divide
    bus.start    = 1'b1;
    bus.dividend = 16'h1234;
    bus.divisor  = 8'h56;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("arst_quotient",  16'(bus.quotient),  16'h0);
    check("arst_remainder", 16'(bus.remainder), 16'h0);
    check("arst_busy",      16'(bus.busy),      16'h0);
    check("arst_done",      16'(bus.done),      16'h0);
    @(posedge clk); #3;
    reset = 1'b0;
    begin
      int seen_done;
      seen_done = 0;
      for (int i = 0; i < 10; i++) begin
        @(posedge clk); #1;
        if (bus.done) seen_done++;
      end
      check("arst_no_done", 16'(seen_done), 16'h0);
    end
    run_div(16'h1234, 8'h56, 16'h0, 1'b0, 1'b0, 9, 8'h36, 8'h10, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
